// File: rtl/alu_exec.sv
// alu_exec: RV32 execute-stage ALU with registered result/zero/busy/done.
// Single-cycle integer ops complete one edge after acceptance. Defining the
// macro RV32M_EN adds a multi-cycle M-extension unit: a shift-add multiplier
// and a restoring divider sequenced by an IDLE/CALC/FIN state machine.
// Without RV32M_EN the M opcodes decode as undefined and busy is tied low.
module alu_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      sel_operation,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy,
  output logic            done
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b01000;
  localparam logic [4:0] OP_SLL  = 5'b00001;
  localparam logic [4:0] OP_SLT  = 5'b00010;
  localparam logic [4:0] OP_SLTU = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_SRA  = 5'b01101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b00111;
  localparam logic [4:0] OP_EQ   = 5'b01100;
  localparam logic [4:0] OP_IDLE = 5'b10000;

  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            done_q, done_d;
  logic            busy_s;
  logic            accept_s;
  logic            wr_s;
  logic            m_fin_s;
  logic [XLEN-1:0] alu_res_s;
  logic [XLEN-1:0] m_res_s;
  logic [4:0]      shamt_s;
`ifdef RV32M_EN
  logic            m_op_s;
`endif

  // A request is only taken while no multi-cycle operation is in flight.
  assign accept_s = start & ~busy_s;
  assign shamt_s  = operand_b[4:0];

  // Decode the opcode and compute the single-cycle result.
  always_comb begin
    alu_res_s = {XLEN{1'b0}};
    wr_s      = 1'b1;
`ifdef RV32M_EN
    m_op_s    = 1'b0;
`endif
    casez (sel_operation)
      OP_ADD:  alu_res_s = operand_a + operand_b;
      OP_SUB:  alu_res_s = operand_a - operand_b;
      OP_SLL:  alu_res_s = operand_a << shamt_s;
      OP_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      OP_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
      OP_XOR:  alu_res_s = operand_a ^ operand_b;
      OP_SRL:  alu_res_s = operand_a >> shamt_s;
      OP_SRA:  alu_res_s = $unsigned($signed(operand_a) >>> shamt_s);
      OP_OR:   alu_res_s = operand_a | operand_b;
      OP_AND:  alu_res_s = operand_a & operand_b;
      OP_EQ:   alu_res_s = {{(XLEN-1){1'b0}}, (operand_a == operand_b)};
      OP_IDLE: wr_s = 1'b0;
`ifdef RV32M_EN
      5'b11???: begin
        wr_s   = 1'b0;
        m_op_s = 1'b1;
      end
`endif
      // Undefined codes complete immediately with a zero result.
      default: alu_res_s = {XLEN{1'b0}};
    endcase
  end

  // Choose what the architectural output registers load this cycle.
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    if (m_fin_s) begin
      result_d = m_res_s;
      zero_d   = (m_res_s == {XLEN{1'b0}});
      done_d   = 1'b1;
    end else if (accept_s && wr_s) begin
      result_d = alu_res_s;
      zero_d   = (alu_res_s == {XLEN{1'b0}});
      done_d   = 1'b1;
    end else begin
      done_d   = 1'b0;
    end
  end

  // Output registers; reset wins over any concurrent request.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= {XLEN{1'b0}};
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign done   = done_q;
  assign busy   = busy_s;

`ifdef RV32M_EN
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              busy_q, busy_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2:0]        mop_q, mop_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [2*XLEN-1:0] prod_q, prod_d, mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   quo_q, quo_d, rem_q, rem_d, dvsr_q, dvsr_d;
  logic              sa_s, sb_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s;
  logic [XLEN:0]     trial_s, diff_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s, rem_fix_s;

  // Operand signedness for the requested M op and the matching magnitudes.
  always_comb begin
    sa_s = 1'b0;
    sb_s = 1'b0;
    case (sel_operation[2:0])
      3'b000, 3'b001, 3'b100, 3'b110: begin
        sa_s = operand_a[XLEN-1];
        sb_s = operand_b[XLEN-1];
      end
      3'b010: begin
        sa_s = operand_a[XLEN-1];
        sb_s = 1'b0;
      end
      default: begin
        sa_s = 1'b0;
        sb_s = 1'b0;
      end
    endcase
    mag_a_s = sa_s ? ({XLEN{1'b0}} - operand_a) : operand_a;
    mag_b_s = sb_s ? ({XLEN{1'b0}} - operand_b) : operand_b;
  end

  // One restoring-division step: shift in the next dividend bit, try subtract.
  assign trial_s = {rem_q, quo_q[XLEN-1]};
  assign diff_s  = trial_s - {1'b0, dvsr_q};

  // Sequencer and iteration datapath for multiply/divide.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mop_d    = mop_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && m_op_s) begin
          state_d  = ST_CALC;
          busy_d   = 1'b1;
          cnt_d    = 5'd0;
          mop_d    = sel_operation[2:0];
          sa_d     = sa_s;
          sb_d     = sb_s;
          a_d      = operand_a;
          b_d      = operand_b;
          prod_d   = {(2*XLEN){1'b0}};
          mcand_d  = {{XLEN{1'b0}}, mag_a_s};
          mplier_d = mag_b_s;
          quo_d    = mag_a_s;
          rem_d    = {XLEN{1'b0}};
          dvsr_d   = mag_b_s;
        end else begin
          busy_d   = 1'b0;
        end
      end
      ST_CALC: begin
        if (mop_q[2] == 1'b0) begin
          if (mplier_q[0]) begin
            prod_d = prod_q + mcand_q;
          end else begin
            prod_d = prod_q;
          end
          mcand_d  = mcand_q << 6'd1;
          mplier_d = mplier_q >> 6'd1;
        end else begin
          // Top bit of diff_s is the borrow: set means the subtract failed.
          if (!diff_s[XLEN]) begin
            rem_d = diff_s[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = trial_s[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Apply signs to the magnitude results and pick the requested word.
  always_comb begin
    prod_fix_s = (sa_q ^ sb_q) ? ({(2*XLEN){1'b0}} - prod_q) : prod_q;
    quo_fix_s  = (sa_q ^ sb_q) ? ({XLEN{1'b0}} - quo_q) : quo_q;
    rem_fix_s  = sa_q ? ({XLEN{1'b0}} - rem_q) : rem_q;
    case (mop_q)
      3'b000:                 m_res_s = prod_fix_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: m_res_s = prod_fix_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         m_res_s = (b_q == {XLEN{1'b0}}) ? {XLEN{1'b1}} : quo_fix_s;
      default:                m_res_s = (b_q == {XLEN{1'b0}}) ? a_q : rem_fix_s;
    endcase
  end

  // M-unit state registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      cnt_q    <= 5'd0;
      mop_q    <= 3'd0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_q      <= {XLEN{1'b0}};
      b_q      <= {XLEN{1'b0}};
      prod_q   <= {(2*XLEN){1'b0}};
      mcand_q  <= {(2*XLEN){1'b0}};
      mplier_q <= {XLEN{1'b0}};
      quo_q    <= {XLEN{1'b0}};
      rem_q    <= {XLEN{1'b0}};
      dvsr_q   <= {XLEN{1'b0}};
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mop_q    <= mop_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
    end
  end

  assign m_fin_s = (state_q == ST_FIN);
  assign busy_s  = busy_q;
`else
  assign m_fin_s = 1'b0;
  assign m_res_s = {XLEN{1'b0}};
  assign busy_s  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vector table, directed
// multi-cycle sequences (RV32M_EN builds) and randomized ops against a model.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  sel;
  logic [31:0] a, b;
  logic [31:0] result;
  logic        zero, busy, done;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_last;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          lat;
    string       nm;
  } vec_t;
  vec_t tbl[$];

  logic [4:0] codes [21] = '{5'b00000, 5'b01000, 5'b00001, 5'b00010, 5'b00011,
                             5'b00100, 5'b00101, 5'b01101, 5'b00110, 5'b00111,
                             5'b01100, 5'b10000, 5'b11000, 5'b11001, 5'b11010,
                             5'b11011, 5'b11100, 5'b11101, 5'b11110, 5'b11111,
                             5'b01001};

  alu_exec #(.XLEN(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .sel_operation(sel),
    .operand_a    (a),
    .operand_b    (b),
    .result       (result),
    .zero         (zero),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: expected result and latency (0 = no done pulse) from the op rules.
  function automatic int model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] prev, output logic [31:0] r);
    longint p;
    int     sh;
    sh    = int'(y[4:0]);
    r     = 32'h0;
    model = 1;
    case (op)
      5'b00000: r = x + y;
      5'b01000: r = x - y;
      5'b00001: r = x << sh;
      5'b00010: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      5'b00011: r = (x < y) ? 32'd1 : 32'd0;
      5'b00100: r = x ^ y;
      5'b00101: r = x >> sh;
      5'b01101: r = $signed(x) >>> sh;
      5'b00110: r = x | y;
      5'b00111: r = x & y;
      5'b01100: r = (x == y) ? 32'd1 : 32'd0;
      5'b10000: begin r = prev; model = 0; end
`ifdef RV32M_EN
      5'b11000: begin p = longint'($signed(x)) * longint'($signed(y)); r = p[31:0];  model = 34; end
      5'b11001: begin p = longint'($signed(x)) * longint'($signed(y)); r = p[63:32]; model = 34; end
      5'b11010: begin p = longint'($signed(x)) * longint'({32'h0, y}); r = p[63:32]; model = 34; end
      5'b11011: begin p = longint'({32'h0, x}) * longint'({32'h0, y}); r = p[63:32]; model = 34; end
      5'b11100: begin
        model = 34;
        if (y == 32'h0) r = 32'hFFFFFFFF;
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'h80000000;
        else r = $signed(x) / $signed(y);
      end
      5'b11101: begin model = 34; r = (y == 32'h0) ? 32'hFFFFFFFF : x / y; end
      5'b11110: begin
        model = 34;
        if (y == 32'h0) r = x;
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'h0;
        else r = $signed(x) % $signed(y);
      end
      5'b11111: begin model = 34; r = (y == 32'h0) ? x : x % y; end
`endif
      default: r = 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       pick = 32'h0;
      1:       pick = 32'hFFFFFFFF;
      2:       pick = 32'h80000000;
      3:       pick = 32'($urandom_range(0, 40));
      default: pick = $urandom;
    endcase
  endfunction

  // Issue one request (called at posedge+1) and check latency, busy and result.
  task automatic run_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input int el, input int poke_at, input string nm);
    int lat;
    int bcnt;
    sel = op; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    bcnt  = 0;
    if (el == 0) begin
      for (int i = 0; i < 3; i++) begin
        chk({nm, "_nodone"}, done, 1'b0);
        @(posedge clk); #1;
      end
      chk({nm, "_held"}, result, er);
      chk({nm, "_zero"}, zero, (er == 32'h0));
    end else begin
      while (done !== 1'b1 && lat < 40) begin
        if (busy === 1'b1) bcnt++;
        if (lat == poke_at) begin
          start = 1'b1; sel = 5'b00000; a = $urandom; b = $urandom;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        lat++;
      end
      start = 1'b0;
      chk({nm, "_lat"},    lat, el);
      chk({nm, "_res"},    result, er);
      chk({nm, "_zero"},   zero, (er == 32'h0));
      chk({nm, "_busyend"}, busy, 1'b0);
      chk({nm, "_busycnt"}, bcnt, el - 1);
      @(posedge clk); #1;
      chk({nm, "_pulse"},  done, 1'b0);
      exp_last = er;
    end
  endtask

  initial begin
    logic [31:0] er, x, y;
    logic [4:0]  op;
    int          el, dcnt;

    reset = 1'b1; start = 1'b0; sel = 5'b0; a = 32'h0; b = 32'h0;
    exp_last = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 32'h0);
    chk("rst_zero",   zero, 1'b1);
    chk("rst_busy",   busy, 1'b0);
    chk("rst_done",   done, 1'b0);
    reset = 1'b0;

    tbl.push_back('{5'b00000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, "add_wrap"});
    tbl.push_back('{5'b01000, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1, "sub"});
    tbl.push_back('{5'b00001, 32'h00000001, 32'h00000023, 32'h00000008, 1, "sll_b40"});
    tbl.push_back('{5'b01101, 32'h80000000, 32'h00000004, 32'hF8000000, 1, "sra"});
    tbl.push_back('{5'b00101, 32'h80000000, 32'h00000004, 32'h08000000, 1, "srl"});
    tbl.push_back('{5'b00010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1, "slt"});
    tbl.push_back('{5'b00011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, "sltu"});
    tbl.push_back('{5'b00100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1, "xor"});
    tbl.push_back('{5'b00110, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1, "or"});
    tbl.push_back('{5'b00111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1, "and"});
    tbl.push_back('{5'b10000, 32'h12345678, 32'h00000000, 32'hF000F000, 0, "idle"});
    tbl.push_back('{5'b01100, 32'h00001234, 32'h00001234, 32'h00000001, 1, "eq"});
    tbl.push_back('{5'b01001, 32'h00000005, 32'h00000005, 32'h00000000, 1, "undef"});
`ifdef RV32M_EN
    tbl.push_back('{5'b11000, 32'h00000003, 32'h00000004, 32'h0000000C, 34, "mul"});
    tbl.push_back('{5'b11001, 32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh"});
    tbl.push_back('{5'b11011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu"});
    tbl.push_back('{5'b11100, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 34, "div_by0"});
    tbl.push_back('{5'b11110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34, "rem_neg"});
    tbl.push_back('{5'b11100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, "div_ovf"});
    tbl.push_back('{5'b11111, 32'h00000007, 32'h00000000, 32'h00000007, 34, "remu_by0"});
    tbl.push_back('{5'b11101, 32'h00000064, 32'h00000007, 32'h0000000E, 34, "divu"});
`else
    tbl.push_back('{5'b11000, 32'h00000003, 32'h00000004, 32'h00000000, 1, "mul_off"});
    tbl.push_back('{5'b11001, 32'h80000000, 32'h80000000, 32'h00000000, 1, "mulh_off"});
`endif

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].lat, 0, tbl[i].nm);
    end

    // Reset coinciding with a request: request dropped, no done.
    reset = 1'b1; start = 1'b1; sel = 5'b00000; a = 32'h1; b = 32'h1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    chk("rststart_result", result, 32'h0);
    chk("rststart_zero",   zero, 1'b1);
    chk("rststart_done",   done, 1'b0);
    @(posedge clk); #1;
    chk("rststart_done2",  done, 1'b0);
    exp_last = 32'h0;

`ifdef RV32M_EN
    // Start while busy is ignored; the divide completes untouched.
    run_op(5'b11101, 32'd1000, 32'd7, 32'd142, 34, 10, "divu_poke");

    // Reset in the middle of a divide aborts it without a done pulse.
    sel = 5'b11101; a = 32'd5000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    chk("abort_busy_before", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy",   busy, 1'b0);
    chk("abort_done",   done, 1'b0);
    chk("abort_result", result, 32'h0);
    chk("abort_zero",   zero, 1'b1);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) dcnt++;
      @(posedge clk); #1;
    end
    chk("abort_quiet", dcnt, 0);
    exp_last = 32'h0;
`endif

    for (int i = 0; i < 120; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : codes[$urandom_range(0, 20)];
      x  = pick();
      y  = pick();
      el = model(op, x, y, exp_last, er);
      run_op(op, x, y, er, el, 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
